lsu_ram_ctrl: RTL and testbench
===============================

// Module: lsu_ram_ctrl
// PURPOSE
//  Load/store initiator between the core execute stage and the ram_2 data memory.
//  Accepts one request at a time over a valid/ready handshake and decodes funct3 into ram_type/sign.
//  Drives single-cycle ram_we/ram_re strobes, waits out the RAM read latency and returns data/status over a held response handshake.
//  Sign/zero extension is done inside the RAM via `sign`; this block passes data_reg through.
// PARAMETERS
//  RD_LAT   1   cycles from the edge sampling ram_re to data_reg valid (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept (IDLE only)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   access size/sign code
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSB-aligned
//  req_rd      in   5   destination register tag, echoed on response
//  resp_valid  out  1   response held until resp_ready
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  load data (0 for stores/errors)
//  resp_rd     out  5   echoed tag
//  resp_load   out  1   response belongs to a load
//  resp_err    out  1   illegal funct3 (or misaligned, see CONFIGURATION)
//  ram_wdat    out  32  RAM write data;  ram_we out 1 write strobe;  ram_re out 1 read strobe
//  ram_type    out  4   byte lanes: 0001 byte, 0011 half, 0111 3/4-word, 1111 word
//  ram_addr    out  32  RAM byte address;  sign out 1 sign-extend on read (0 on stores)
//  data_reg    in   32  RAM read data
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; FSM=IDLE; no response emitted.
//  funct3: 000 byte/s, 001 half/s, 010 word, 011 3/4/s, 100 byte/u, 101 half/u, 110 3/4/u, 111 illegal.
//  FSM IDLE->ISSUE->(WAIT)->RESP->IDLE; only IDLE has req_ready=1.
//  IDLE: on req_valid&req_ready latch all req fields; go ISSUE (or RESP with err if illegal).
//  ISSUE (1 cycle): ram_addr/ram_type/ram_wdat/sign driven from latch; store: ram_we=1 -> RESP;
//   load: ram_re=1 -> WAIT. Strobes are 0 in every other state; addr/type/wdat hold.
//  WAIT: exactly RD_LAT cycles (down-counter); data_reg captured into resp_rdata on the last WAIT edge.
//  Latency (accept edge = T): store resp_valid from T+2; load resp_valid from T+2+RD_LAT.
//  RESP: resp_valid=1, all resp_* stable until resp_ready=1; handshake edge -> IDLE, resp_valid=0.
//  Back-to-back: new request accepted earliest the cycle after response handshake (no overlap).
//  Illegal funct3: no RAM strobe, resp_err=1, resp_rdata=0, response 1 cycle after accept.
//  Reset asserted in any state: strobes drop immediately, pending response discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, 3/4 with addr[1]=1
//   -> no RAM strobe, resp_err=1, resp_rdata=0, same timing as illegal funct3.
//  Not defined: every legal access issued unchanged; RAM handles unaligned lanes; resp_err only for 111.
// TESTING
//  1 store word 0x000000B4 @0x44, then load funct3=010 @0x44 -> ram_we pulse T+1, resp_rdata=0x000000B4 at T+3 (RD_LAT=1).
//  2 store byte 0xC1 @0x0D; load 000 -> sign=1, type=0001, resp_rdata=0xFFFFFFC1; load 100 -> 0x000000C1.
//  3 store half 0x80AB @0x22; load 101 -> sign=0, type=0011, 0x000080AB; load 001 -> 0xFFFF80AB.
//  4 funct3=111 load -> no ram_re/ram_we ever high, resp_valid T+1, resp_err=1, rdata=0.
//  5 resp_ready low 3 cycles during RESP -> resp_* stable, req_ready=0, no second strobe; accept after.
//  6 load word @0x45 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, no ram_re; without: ram_re pulse, err=0.
//  7 rst pulsed during WAIT -> all outputs reset within the cycle, no resp_valid, next request served normally.

Source files
------------

// File: rtl/lsu_ram_ctrl_if.sv
// Request/response and RAM-side signal bundle for lsu_ram_ctrl.
// slave is the controller's view; master is the core plus RAM environment.
interface lsu_ram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_load;
    logic        resp_err;

    logic [31:0] ram_wdat;
    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_type;
    logic [31:0] ram_addr;
    logic        sign;
    logic [31:0] data_reg;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  resp_ready, data_reg,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_load, resp_err,
        output ram_wdat, ram_we, ram_re, ram_type, ram_addr, sign
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output resp_ready, data_reg,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_load, resp_err,
        input  ram_wdat, ram_we, ram_re, ram_type, ram_addr, sign
    );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// Load/store initiator between execute stage and ram_2: one request at a time, single-cycle strobes.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word/3-4 accesses with resp_err.
module lsu_ram_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    lsu_ram_ctrl_if.slave bus
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic [31:0]        resp_rdata_r;
    logic [4:0]         resp_rd_r;
    logic               resp_load_r;
    logic               resp_err_r;
    logic [31:0]        ram_wdat_r;
    logic               ram_we_r;
    logic               ram_re_r;
    logic [3:0]         ram_type_r;
    logic [31:0]        ram_addr_r;
    logic               sign_r;

    logic               reject_s;
    logic [3:0]         lanes_s;
    logic               signed_s;

    function automatic logic [3:0] lanes_of(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return 4'b0001;
            3'b001:  return 4'b0011;
            3'b010:  return 4'b1111;
            3'b011:  return 4'b0111;
            3'b100:  return 4'b0001;
            3'b101:  return 4'b0011;
            3'b110:  return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic signed_of(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return 1'b1;
            3'b001:  return 1'b1;
            3'b011:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [3:0] lanes, input logic [1:0] addr_lo);
        case (lanes)
            4'b0011: return addr_lo[0];
            4'b0111: return addr_lo[1];
            4'b1111: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Decode the incoming request and decide whether it is rejected without touching the RAM
    always_comb begin
        lanes_s  = lanes_of(bus.req_funct3);
        signed_s = signed_of(bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.req_funct3 == 3'b111) begin
            reject_s = 1'b1;
        end else begin
            reject_s = misaligned(lanes_s, bus.req_addr[1:0]);
        end
`else
        if (bus.req_funct3 == 3'b111) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
`endif
    end

    // Request/response FSM; every output is a register so strobes never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_cnt_r   <= {CNT_W{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_rd_r    <= 5'd0;
            resp_load_r  <= 1'b0;
            resp_err_r   <= 1'b0;
            ram_wdat_r   <= 32'h0000_0000;
            ram_we_r     <= 1'b0;
            ram_re_r     <= 1'b0;
            ram_type_r   <= 4'b0000;
            ram_addr_r   <= 32'h0000_0000;
            sign_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        req_ready_r  <= 1'b0;
                        resp_rd_r    <= bus.req_rd;
                        resp_load_r  <= ~bus.req_we;
                        resp_rdata_r <= 32'h0000_0000;
                        if (reject_s) begin
                            resp_err_r   <= 1'b1;
                            resp_valid_r <= 1'b1;
                            state_r      <= RESP;
                        end else begin
                            resp_err_r <= 1'b0;
                            ram_addr_r <= bus.req_addr;
                            ram_type_r <= lanes_s;
                            ram_wdat_r <= bus.req_wdata;
                            sign_r     <= bus.req_we ? 1'b0 : signed_s;
                            ram_we_r   <= bus.req_we;
                            ram_re_r   <= ~bus.req_we;
                            state_r    <= ISSUE;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    ram_we_r <= 1'b0;
                    ram_re_r <= 1'b0;
                    if (resp_load_r) begin
                        wait_cnt_r <= CNT_W'(RD_LAT - 1);
                        state_r    <= WAIT;
                    end else begin
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end
                end
                WAIT: begin
                    // Last WAIT edge is the one where the RAM data becomes valid
                    if (wait_cnt_r == {CNT_W{1'b0}}) begin
                        resp_rdata_r <= bus.data_reg;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    ram_we_r     <= 1'b0;
                    ram_re_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_rd    = resp_rd_r;
    assign bus.resp_load  = resp_load_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.ram_wdat   = ram_wdat_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_re     = ram_re_r;
    assign bus.ram_type   = ram_type_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.sign       = sign_r;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Self-checking bench for lsu_ram_ctrl: directed cases, randomized traffic, reset during WAIT.
// Contains a 256-byte RAM model and a shadow-memory reference computed from funct3 rules.
module tb_lsu_ram_ctrl;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ram_ctrl_if bus ();
    lsu_ram_ctrl #(.RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  mem     [256];
    bit          mem_ready = 1'b0;
    int          cyc = 0, we_cnt = 0, re_cnt = 0, strobe_cyc = 0;
    logic [31:0] st_addr, st_wdat;
    logic [3:0]  st_type;
    logic        st_sign;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input int nb, input logic sg);
        logic [31:0] r;
        r = (nb >= 4) ? v : (v & ~(32'hFFFF_FFFF << (8 * nb)));
        if (sg && nb < 4 && nb > 0 && r[8 * nb - 1]) r = r | (32'hFFFF_FFFF << (8 * nb));
        return r;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b011, 3'b110: return 3;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // RAM model: lanes and sign come from the DUT's ram_type/sign, one-cycle read latency
    always @(posedge clk) begin
        logic [31:0] v;
        int nb;
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
            mem_ready = 1'b1;
        end
        cyc++;
        nb = $countones(bus.ram_type);
        if (bus.ram_we) begin
            we_cnt++; strobe_cyc = cyc;
            st_addr = bus.ram_addr; st_wdat = bus.ram_wdat; st_type = bus.ram_type; st_sign = bus.sign;
            for (int j = 0; j < nb; j++) mem[8'(bus.ram_addr[7:0] + 8'(j))] = bus.ram_wdat[8 * j +: 8];
        end
        if (bus.ram_re) begin
            re_cnt++; strobe_cyc = cyc;
            st_addr = bus.ram_addr; st_wdat = bus.ram_wdat; st_type = bus.ram_type; st_sign = bus.sign;
            v = 32'h0;
            for (int j = 0; j < nb; j++) v[8 * j +: 8] = mem[8'(bus.ram_addr[7:0] + 8'(j))];
            bus.data_reg <= extend(v, nb, bus.sign);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int hold);
        int k, nb, we0, re0, acc_cyc, exp_lat;
        logic sg, exp_err;
        logic [31:0] exp_rdata, v, snap;
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        nb = size_of(f3);
        sg = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b011);
        exp_err = (nb == 0);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00) || (nb == 3 && addr[1])) exp_err = 1'b1;
`endif
        exp_rdata = 32'h0;
        if (!exp_err && we) begin
            for (int j = 0; j < nb; j++) ref_mem[8'(addr[7:0] + 8'(j))] = wdata[8 * j +: 8];
        end else if (!exp_err) begin
            v = 32'h0;
            for (int j = 0; j < nb; j++) v[8 * j +: 8] = ref_mem[8'(addr[7:0] + 8'(j))];
            exp_rdata = extend(v, nb, sg);
        end
        exp_lat = exp_err ? 1 : (we ? 2 : 2 + RD_LAT);
        we0 = we_cnt; re0 = re_cnt; acc_cyc = cyc + 1;
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1;
        while (!bus.resp_valid && k < 30) begin @(negedge clk); k++; end
        chk("resp_latency", 32'(k), 32'(exp_lat));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_rd", 32'(bus.resp_rd), 32'(rd));
        chk("resp_load", 32'(bus.resp_load), 32'(!we));
        chk("we_strobes", 32'(we_cnt - we0), (!exp_err && we) ? 32'd1 : 32'd0);
        chk("re_strobes", 32'(re_cnt - re0), (!exp_err && !we) ? 32'd1 : 32'd0);
        if (!exp_err) begin
            chk("strobe_cycle", 32'(strobe_cyc), 32'(acc_cyc + 1));
            chk("ram_addr", st_addr, addr);
            chk("ram_type", 32'(st_type), 32'((32'd1 << nb) - 32'd1));
            chk("ram_sign", 32'(st_sign), 32'(!we && sg));
            if (we) chk("ram_wdat", st_wdat, wdata);
        end
        snap = bus.resp_rdata ^ {25'd0, bus.resp_err, bus.resp_load, bus.resp_rd};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_stable", bus.resp_rdata ^ {25'd0, bus.resp_err, bus.resp_load, bus.resp_rd}, snap);
            chk("hold_not_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_dropped", 32'(bus.resp_valid), 32'd0);
        chk("ready_after_hs", 32'(bus.req_ready), 32'd1);
        chk("no_extra_strobe", 32'(we_cnt - we0 + re_cnt - re0), exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.req_rd = 5'd0; bus.resp_ready = 1'b0; bus.data_reg = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_strobes", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);
        chk("rst_ram_bus", bus.ram_addr | bus.ram_wdat | {27'd0, bus.ram_type, bus.sign}, 32'd0);
        chk("rst_resp_bus", bus.resp_rdata | {25'd0, bus.resp_rd, bus.resp_load, bus.resp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        xact(1'b1, 3'b010, 32'h44, 32'h0000_00B4, 5'd1, 0);
        xact(1'b0, 3'b010, 32'h44, 32'h0,         5'd2, 0);
        chk("t1_word", bus.resp_rdata, 32'h0000_00B4);
        xact(1'b1, 3'b000, 32'h0D, 32'h0000_00C1, 5'd3, 0);
        xact(1'b0, 3'b000, 32'h0D, 32'h0,         5'd4, 0);
        chk("t2_byte_s", bus.resp_rdata, 32'hFFFF_FFC1);
        xact(1'b0, 3'b100, 32'h0D, 32'h0,         5'd5, 1);
        chk("t2_byte_u", bus.resp_rdata, 32'h0000_00C1);
        xact(1'b1, 3'b001, 32'h22, 32'h0000_80AB, 5'd6, 0);
        xact(1'b0, 3'b101, 32'h22, 32'h0,         5'd7, 0);
        chk("t3_half_u", bus.resp_rdata, 32'h0000_80AB);
        xact(1'b0, 3'b001, 32'h22, 32'h0,         5'd8, 0);
        chk("t3_half_s", bus.resp_rdata, 32'hFFFF_80AB);
        xact(1'b0, 3'b111, 32'h40, 32'h0,         5'd9, 0);
        xact(1'b0, 3'b010, 32'h44, 32'h0,         5'd10, 3);
        xact(1'b0, 3'b010, 32'h45, 32'h0,         5'd11, 0);

        for (int n = 0; n < 40; n++) begin
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                 $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        // Reset while the controller is waiting on RAM read data
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_rd = 5'd12;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstw_strobes", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);
        chk("rstw_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstw_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        xact(1'b0, 3'b010, 32'h44, 32'h0, 5'd13, 0);
        chk("post_rst_load", bus.resp_rdata, 32'h0000_00B4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
